// File: rtl/bomb_placer.sv
// Places exactly NUM_BOMBS mines on a GRID_SIZE x GRID_SIZE board using a free-running
// Fibonacci LFSR; cells flagged in safe_mask never receive a mine.
module bomb_placer #(
  parameter int                    GRID_SIZE  = 3,
  parameter int                    NUM_BOMBS  = 2,
  parameter int                    LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 8'hA5,
  parameter int                    MAX_TRIES  = 255
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]   safe_mask,
  output logic                             busy,
  output logic                             done,
  output logic                             fail,
  output logic [GRID_SIZE*GRID_SIZE-1:0]   bomb_grid
);

  localparam int N     = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Maximal-length tap sets (bit positions, 0-based) for the common widths.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0003 << (w - 2);
    endcase
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(tap_mask(LFSR_WIDTH));

  logic [1:0]            state;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [CNT_W-1:0]      count;
  logic [7:0]            tries;
  logic [IDX_W-1:0]      cand;
  logic [N-1:0]          cand_hot;
  logic                  cand_blocked;
  logic                  accept;
  logic                  feedback;

  assign feedback = ^(lfsr & TAPS);

  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr <= SEED;
    end else if (lfsr == '0) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], feedback};
    end
  end

  assign cand = lfsr[IDX_W-1:0];

  // One-hot decode keeps out-of-range candidates from ever indexing past the grid.
  always_comb begin
    cand_hot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_hot[i] = (cand == IDX_W'(i));
    end
    cand_blocked = |(cand_hot & (bomb_grid | safe_mask));
    accept       = (state == DRAW) && (|cand_hot) && !cand_blocked;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      bomb_grid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      count     <= '0;
      tries     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bomb_grid <= '0;
            fail      <= 1'b0;
            if (NUM_BOMBS == 0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
              busy  <= 1'b1;
              count <= CNT_W'(NUM_BOMBS);
              tries <= '0;
            end
          end
        end
        DRAW: begin
          tries <= tries + 8'd1;
          if (accept) begin
            bomb_grid <= bomb_grid | cand_hot;
            count     <= count - CNT_W'(1);
          end
          // Completing the last mine takes priority over the try-limit abort.
          if (accept && count == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tries == 8'(MAX_TRIES - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            fail  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_placer.sv
// Scoreboard bench for bomb_placer: stimulus queues expected layouts, a monitor checks each done pulse.
module tb_bomb_placer;

  localparam int          GRID = 3;
  localparam int          N    = 9;
  localparam int          NB   = 2;
  localparam int          MAXT = 255;
  localparam logic [7:0]  SEED = 8'hA5;

  typedef struct {
    logic [8:0] grid;
    logic       fail;
    int         done_cyc;
    int         busy_cycles;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start_z = 1'b0;
  logic [8:0] safe_mask = '0;
  logic [8:0] zero_mask = '0;
  logic       busy, done, fail;
  logic [8:0] bomb_grid;
  logic       busy_z, done_z, fail_z;
  logic [8:0] grid_z;

  exp_t       sb[$];
  int         cyc = 0;
  logic [7:0] model_lfsr;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clock = ~clock;

  bomb_placer #(.GRID_SIZE(GRID), .NUM_BOMBS(NB), .LFSR_WIDTH(8), .SEED(SEED), .MAX_TRIES(MAXT)) dut (
    .clock(clock), .reset(reset), .start(start), .safe_mask(safe_mask),
    .busy(busy), .done(done), .fail(fail), .bomb_grid(bomb_grid)
  );

  bomb_placer #(.GRID_SIZE(GRID), .NUM_BOMBS(0), .LFSR_WIDTH(8), .SEED(SEED), .MAX_TRIES(MAXT)) dut_zero (
    .clock(clock), .reset(reset), .start(start_z), .safe_mask(zero_mask),
    .busy(busy_z), .done(done_z), .fail(fail_z), .bomb_grid(grid_z)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    if (v == 8'h00) return SEED;
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference placement: replays the draw sequence starting from the LFSR value seen with start.
  function automatic void model_run(input logic [7:0] l0, input logic [8:0] mask,
                                    output logic [8:0] g, output logic f, output int lat);
    logic [7:0] v;
    logic [3:0] c;
    int         left;
    v    = lfsr_next(l0);
    g    = '0;
    f    = 1'b1;
    lat  = MAXT + 1;
    left = NB;
    for (int t = 0; t < MAXT; t++) begin
      c = v[3:0];
      if (c < 4'(N)) begin
        if (!g[c] && !mask[c]) begin
          g[c] = 1'b1;
          left--;
          if (left == 0) begin
            f   = 1'b0;
            lat = t + 2;
            break;
          end
        end
      end
      v = lfsr_next(v);
    end
  endfunction

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    model_lfsr <= !reset ? SEED : lfsr_next(model_lfsr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse on the main instance is matched against the oldest expectation.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done=1 expected no pending run at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            check("grid", 32'(bomb_grid), 32'(e.grid));
            check("fail_at_done", 32'(fail), 32'(e.fail));
            check("done_cycle", 32'(cyc), 32'(e.done_cyc));
            check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
            check("busy_at_done", 32'(busy), 32'd0);
            check("safe_overlap", 32'(bomb_grid & safe_mask), 32'd0);
            if (!e.fail) check("popcount", 32'($countones(bomb_grid)), 32'(NB));
            else         check("popcount_le", 32'($countones(bomb_grid) <= NB), 32'd1);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic launch(input logic [8:0] mask, input bit use_model, input logic [8:0] g_in,
                        input logic f_in, input int lat_in, output exp_t e);
    logic [8:0] g;
    logic       f;
    int         lat;
    @(posedge clock);
    #1;
    safe_mask = mask;
    start     = 1'b1;
    if (use_model) model_run(model_lfsr, mask, g, f, lat);
    else begin
      g   = g_in;
      f   = f_in;
      lat = lat_in;
    end
    e.grid        = g;
    e.fail        = f;
    e.done_cyc    = cyc + lat;
    e.busy_cycles = lat - 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clock);
    check("drain", 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic run(input logic [8:0] mask, output exp_t e);
    launch(mask, 1'b1, '0, 1'b0, 0, e);
    @(posedge clock);
    #1;
    start = 1'b0;
    drain();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    exp_t       e, ea, eb;
    logic [8:0] ga, gb;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_grid", 32'(bomb_grid), 32'd0);
    check("rst_grid_z", 32'(grid_z), 32'd0);

    // Plain run, then the layout must hold while idle.
    run(9'h000, e);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("grid_hold", 32'(bomb_grid), 32'(e.grid));
    check("done_idle", 32'(done), 32'd0);

    // Zero-mine instance: done one cycle after start, never busy.
    @(posedge clock);
    #1 start_z = 1'b1;
    @(negedge clock);
    check("z_done_early", 32'(done_z), 32'd0);
    check("z_busy0", 32'(busy_z), 32'd0);
    @(posedge clock);
    #1 start_z = 1'b0;
    @(negedge clock);
    check("z_done", 32'(done_z), 32'd1);
    check("z_grid", 32'(grid_z), 32'd0);
    check("z_busy1", 32'(busy_z), 32'd0);
    check("z_fail", 32'(fail_z), 32'd0);
    @(negedge clock);
    check("z_done_pulse", 32'(done_z), 32'd0);
    check("z_busy2", 32'(busy_z), 32'd0);

    // First clicked cell protected over many runs with varying LFSR phase.
    for (int i = 0; i < 50; i++) begin
      repeat (i % 4) @(posedge clock);
      run(9'h001, e);
    end

    // Whole board safe: abort after MAX_TRIES draws, empty grid, fail held until next start.
    launch(9'h1FF, 1'b0, 9'h000, 1'b1, MAXT + 1, e);
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("busy_in_draw", 32'(busy), 32'd1);
    drain();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("fail_held", 32'(fail), 32'd1);
    launch(9'h000, 1'b1, '0, 1'b0, 0, e);
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("fail_cleared", 32'(fail), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    drain();

    // Reset in the middle of a long (unsatisfiable) draw.
    launch(9'h1FE, 1'b1, '0, 1'b0, 0, e);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("midrst_grid", 32'(bomb_grid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_fail", 32'(fail), 32'd0);
    repeat (10) @(negedge clock);
    run(9'h000, e);

    // start held through DRAW and re-pulsed during DONE: one done only.
    launch(9'h000, 1'b1, '0, 1'b0, 0, ea);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1 start = 1'b0;
    while (cyc < ea.done_cyc) begin
      @(posedge clock);
      #1;
    end
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    drain();
    repeat (6) @(posedge clock);
    #1 ga = bomb_grid;
    run(9'h000, eb);
    gb = bomb_grid;
    if (ea.grid != eb.grid) check("layouts_differ", 32'(ga != gb), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
